// File: rtl/inject_scheduler_if.sv
// -----------------------------------------------------------------------------
// inject_scheduler_if
//  Bundles the PE handshake, the four incoming mesh channels and the injection /
//  loopback outputs of one router node's local-injection scheduler.
//  Signals
//   pe_valid / pe_ready / pe_flit    PE -> scheduler flit handshake
//   north_in..west_in                incoming channel flits, [10]=occupied
//   inj_flit / inj_sel               head flit and one-hot target {W,E,S,N}
//   loop_valid / loop_flit           head destined to this node (local eject)
//   starve                           head has waited too long for a channel
//   inj_count                        running count of injected flits
//  Modports
//   master : drives PE and channel inputs (PE/router side, testbench)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface inject_scheduler_if;
  logic        pe_valid;
  logic        pe_ready;
  logic [10:0] pe_flit;
  logic [10:0] north_in;
  logic [10:0] south_in;
  logic [10:0] east_in;
  logic [10:0] west_in;
  logic [10:0] inj_flit;
  logic [3:0]  inj_sel;
  logic        loop_valid;
  logic [10:0] loop_flit;
  logic        starve;
  logic [15:0] inj_count;

  modport master (
    output pe_valid, pe_flit, north_in, south_in, east_in, west_in,
    input  pe_ready, inj_flit, inj_sel, loop_valid, loop_flit, starve, inj_count
  );

  modport slave (
    input  pe_valid, pe_flit, north_in, south_in, east_in, west_in,
    output pe_ready, inj_flit, inj_sel, loop_valid, loop_flit, starve, inj_count
  );
endinterface

// File: rtl/inject_scheduler.sv
// -----------------------------------------------------------------------------
// inject_scheduler
//  Local-injection scheduler for one node of a bufferless deflection mesh.
//  Flits from the PE are queued in a small FIFO with their route direction
//  computed at push time. Each cycle the head flit is offered to the first
//  empty incoming channel found scanning round-robin from rr_ptr, or, when it
//  is addressed to this node, handed straight to the local loopback path.
//  A saturating wait counter raises 'starve' when a non-local head cannot find
//  a free channel for STARVE_LIMIT cycles.
//  Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards all queued flits
//   bus    inject_scheduler_if.slave (PE handshake, channels, injection outputs)
// -----------------------------------------------------------------------------
module inject_scheduler #(
  parameter int          DEPTH        = 4,
  parameter logic [2:0]  LOCAL_ROW    = 3'd4,
  parameter logic [2:0]  LOCAL_COL    = 3'd4,
  parameter int          STARVE_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inject_scheduler_if.slave    bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] LIMIT8   = 8'(STARVE_LIMIT);
  localparam logic [2:0] DIR_LOC  = 3'b100;

  // Stored entry: {reserved bit, dir[2:0], dest[5:0]}; the valid bit is implied.
  logic [9:0]  mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]  rr_q, rr_d;
  logic [7:0]  wait_q, wait_d;
  logic        starve_q, starve_d;
  logic [15:0] cnt_q, cnt_d;

  logic        empty, full, push, pop;
  logic [9:0]  head;
  logic        head_local;
  logic [3:0]  free_ch;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic [1:0]  idx;
  logic [3:0]  inj_sel;
  logic        loop_valid;
  logic        unused_bits;

  // Dimension-ordered routing: columns are resolved before rows.
  function automatic logic [2:0] route_dir(input logic [5:0] dest);
    if (dest[2:0] > LOCAL_COL)      return 3'b000;
    else if (dest[2:0] < LOCAL_COL) return 3'b001;
    else if (dest[5:3] > LOCAL_ROW) return 3'b010;
    else if (dest[5:3] < LOCAL_ROW) return 3'b011;
    else                            return DIR_LOC;
  endfunction

  assign unused_bits = ^{bus.pe_flit[10], bus.pe_flit[8:6],
                         bus.north_in[9:0], bus.south_in[9:0],
                         bus.east_in[9:0], bus.west_in[9:0]};

  // FIFO storage carries no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {bus.pe_flit[9], route_dir(bus.pe_flit[5:0]), bus.pe_flit[5:0]};
    end
  end

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full refuses a push even if the head leaves in the same cycle.
    push       = bus.pe_valid && !full;
    head       = mem[rd_ptr_q[AW-1:0]];
    head_local = !empty && (head[8:6] == DIR_LOC);
    free_ch    = {~bus.west_in[10], ~bus.east_in[10], ~bus.south_in[10], ~bus.north_in[10]};

    // Round-robin scan from rr_q, wrapping through the 2-bit index.
    grant     = 4'b0000;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (grant == 4'b0000 && free_ch[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end

    inj_sel    = (!empty && !head_local) ? grant : 4'b0000;
    loop_valid = head_local;
    pop        = (inj_sel != 4'b0000) || loop_valid;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rr_d     = (inj_sel != 4'b0000) ? grant_idx + 2'd1 : rr_q;
    cnt_d    = cnt_q + {15'd0, (inj_sel != 4'b0000)};

    wait_d = wait_q;
    if (pop) begin
      wait_d = 8'd0;
    end else if (!empty && !head_local && (free_ch == 4'b0000) && (wait_q < LIMIT8)) begin
      wait_d = wait_q + 8'd1;
    end
    // Decoded from the next count so starve and the counter move on the same edge.
    starve_d = (wait_d == LIMIT8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_q     <= 2'd0;
      wait_q   <= 8'd0;
      starve_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pe_ready   = !full;
  assign bus.inj_sel    = inj_sel;
  assign bus.loop_valid = loop_valid;
  assign bus.inj_flit   = empty ? 11'd0 : {1'b1, head};
  assign bus.loop_flit  = loop_valid ? {1'b1, head} : 11'd0;
  assign bus.starve     = starve_q;
  assign bus.inj_count  = cnt_q;

endmodule

// File: tb/tb_inject_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inject_scheduler
//  Directed scenarios plus randomized traffic for inject_scheduler, checked each
//  cycle against a queue-based reference model of the scheduling rules.
// -----------------------------------------------------------------------------
module tb_inject_scheduler;
  localparam int DEPTH = 4;
  localparam int LR    = 4;
  localparam int LC    = 4;
  localparam int LIMIT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inject_scheduler_if bus();

  inject_scheduler #(
    .DEPTH(DEPTH), .LOCAL_ROW(3'd4), .LOCAL_COL(3'd4), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  // Reference model state
  logic [6:0]  mq[$];          // {reserved, dest}
  int          m_rr;
  int          m_wait;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_dir(input logic [5:0] d);
    int row, col;
    row = int'(d[5:3]);
    col = int'(d[2:0]);
    if (col > LC) return 3'd0;
    if (col < LC) return 3'd1;
    if (row > LR) return 3'd2;
    if (row < LR) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [10:0] mk_flit(input logic [5:0] dest);
    logic [4:0] junk;
    junk = 5'($urandom);
    return {junk[4:3], junk[2:0], dest};
  endfunction

  function automatic logic [5:0] rand_dest(input bit allow_local);
    logic [5:0] d;
    d = 6'($urandom);
    if (!allow_local && d == 6'o44) d = 6'o45;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr   = 0;
    m_wait = 0;
    m_cnt  = 16'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, bus.pe_ready},   32'd1);
    check({tag, "_sel"},    {28'd0, bus.inj_sel},    32'd0);
    check({tag, "_loop"},   {31'd0, bus.loop_valid}, 32'd0);
    check({tag, "_inj"},    {21'd0, bus.inj_flit},   32'd0);
    check({tag, "_lflit"},  {21'd0, bus.loop_flit},  32'd0);
    check({tag, "_starve"}, {31'd0, bus.starve},     32'd0);
    check({tag, "_count"},  {16'd0, bus.inj_count},  32'd0);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  // occ bit k set = channel k occupied (0=N,1=S,2=E,3=W).
  task automatic step(input logic v, input logic [10:0] flit, input logic [3:0] occ);
    logic [3:0]  e_sel;
    logic        e_loop, e_ready, has_head, popped, accepted;
    logic [10:0] e_inj, e_lf;
    logic [2:0]  hd;
    int          k, gk;
    bit          found;

    @(negedge clk);
    bus.pe_valid = v;
    bus.pe_flit  = flit;
    bus.north_in = {occ[0], 10'($urandom)};
    bus.south_in = {occ[1], 10'($urandom)};
    bus.east_in  = {occ[2], 10'($urandom)};
    bus.west_in  = {occ[3], 10'($urandom)};
    #1;

    e_ready  = (mq.size() < DEPTH);
    e_sel    = 4'd0;
    e_loop   = 1'b0;
    e_inj    = 11'd0;
    e_lf     = 11'd0;
    has_head = (mq.size() > 0);
    hd       = 3'd0;
    gk       = 0;
    found    = 1'b0;
    if (has_head) begin
      hd    = ref_dir(mq[0][5:0]);
      e_inj = {1'b1, mq[0][6], hd, mq[0][5:0]};
      if (hd == 3'd4) begin
        e_loop = 1'b1;
        e_lf   = e_inj;
      end else begin
        for (int i = 0; i < 4; i++) begin
          k = (m_rr + i) % 4;
          if (!found && !occ[k]) begin
            found = 1'b1;
            gk    = k;
          end
        end
        if (found) e_sel = 4'b0001 << gk;
      end
    end

    check("ready",  {31'd0, bus.pe_ready},   {31'd0, e_ready});
    check("sel",    {28'd0, bus.inj_sel},    {28'd0, e_sel});
    check("sel_occ",{28'd0, bus.inj_sel & occ}, 32'd0);
    check("loop",   {31'd0, bus.loop_valid}, {31'd0, e_loop});
    check("inj",    {21'd0, bus.inj_flit},   {21'd0, e_inj});
    check("lflit",  {21'd0, bus.loop_flit},  {21'd0, e_lf});
    check("starve", {31'd0, bus.starve},     {31'd0, (m_wait == LIMIT)});
    check("count",  {16'd0, bus.inj_count},  {16'd0, m_cnt});

    @(posedge clk);
    popped   = (e_sel != 4'd0) || e_loop;
    accepted = v && e_ready;
    if (popped) begin
      void'(mq.pop_front());
      m_wait = 0;
    end else if (has_head && hd != 3'd4 && occ == 4'hF && m_wait < LIMIT) begin
      m_wait++;
    end
    if (e_sel != 4'd0) begin
      m_rr  = (gk + 1) % 4;
      m_cnt = m_cnt + 16'd1;
    end
    if (accepted) mq.push_back({flit[9], flit[5:0]});
    if (verbose && (popped || accepted))
      $display("t=%0t push=%0d pop=%0d sel=%b loop=%0d flit=%h cnt=%0d q=%0d",
               $time, accepted, popped, e_sel, e_loop, e_inj, m_cnt, mq.size());
  endtask

  initial begin
    int guard;
    logic [3:0] occ;
    int busy_pct;

    bus.pe_valid = 1'b0;
    bus.pe_flit  = 11'd0;
    bus.north_in = 11'd0;
    bus.south_in = 11'd0;
    bus.east_in  = 11'd0;
    bus.west_in  = 11'd0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single flit to row7,col4 -> north, rr advances
    step(1'b1, mk_flit(6'o74), 4'h0);
    step(1'b0, 11'd0, 4'h0);
    step(1'b0, 11'd0, 4'h0);

    // 2: four flits queued behind busy channels, then drained round-robin
    for (int i = 0; i < 4; i++) step(1'b1, mk_flit(rand_dest(1'b0)), 4'hF);
    for (int i = 0; i < 5; i++) step(1'b0, 11'd0, 4'h0);

    // 3: local destination goes to loopback
    step(1'b1, mk_flit(6'o44), 4'h0);
    step(1'b0, 11'd0, 4'h0);
    step(1'b0, 11'd0, 4'h0);

    // 4: starvation with all channels busy, then east frees
    step(1'b1, mk_flit(rand_dest(1'b0)), 4'hF);
    for (int i = 0; i < 20; i++) step(1'b0, 11'd0, 4'hF);
    step(1'b0, 11'd0, 4'b1011);
    step(1'b0, 11'd0, 4'hF);

    // 5: fill the FIFO, fifth push refused, one pop reopens it
    for (int i = 0; i < 6; i++) step(1'b1, mk_flit(rand_dest(1'b0)), 4'hF);
    step(1'b0, 11'd0, 4'b1110);
    step(1'b0, 11'd0, 4'hF);
    for (int i = 0; i < 6; i++) step(1'b0, 11'd0, 4'h0);

    // Randomized traffic with varying channel load
    for (int blk = 0; blk < 15; blk++) begin
      busy_pct = (blk % 3 == 0) ? 95 : ((blk % 3 == 1) ? 50 : 10);
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < 4; c++) occ[c] = ($urandom_range(99) < busy_pct);
        step(($urandom_range(2) != 0),
             mk_flit(($urandom_range(7) == 0) ? 6'o44 : rand_dest(1'b0)), occ);
      end
    end

    // 6: asynchronous reset with three queued flits and starve high
    for (int i = 0; i < 3; i++) step(1'b1, mk_flit(rand_dest(1'b0)), 4'hF);
    for (int i = 0; i < 16; i++) step(1'b0, 11'd0, 4'hF);
    @(negedge clk);
    #1 check("pre_rst_starve", {31'd0, bus.starve}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap: inject until the count reaches FFFF, then once more
    verbose = 1'b0;
    guard   = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(1'b1, mk_flit(rand_dest(1'b0)), 4'h0);
      guard++;
    end
    check("wrap_reach", {16'd0, m_cnt}, 32'h0000FFFF);
    verbose = 1'b1;
    step(1'b0, 11'd0, 4'h0);
    step(1'b0, 11'd0, 4'h0);
    @(negedge clk);
    #1 check("wrap_zero", {16'd0, bus.inj_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
